ins_queue: RTL and testbench
============================

// Module: ins_queue
// PURPOSE
//  Circular instruction queue between fetch and decode. Buffers fetched {ins, pc} pairs,
//  presents the oldest entry to decode via decode_flag/ins/ins_pc, and pops it when decode
//  reports decode_ok (decode raises it only when ROB and RS both have room). Flushed on
//  branch mispredict so no wrong-path instruction reaches decode.
// PARAMETERS
//  DEPTH   16  number of entries; power of two, >= 4
//  ADDR_W  4   log2(DEPTH); pointer width (count is ADDR_W+1 bits)
//  AF_GAP  2   almost_full asserts when free slots <= AF_GAP (covers fetch latency)
// PORTS
//  clk_in       in   1   clock; all state on rising edge
//  rstn_in      in   1   reset, synchronous, active-low
//  rdy_in       in   1   global ready; low = freeze all state
//  flush_in     in   1   mispredict flush; empties the queue
//  push_valid   in   1   fetch presents a new instruction
//  push_ins     in   32  instruction word
//  push_pc      in   32  instruction address
//  full         out  1   count == DEPTH; push ignored
//  almost_full  out  1   DEPTH - count <= AF_GAP
//  decode_flag  out  1   head entry valid for decode
//  ins          out  32  head instruction word
//  ins_pc       out  32  head instruction pc
//  decode_ok    in   1   decode consumed head this cycle
//  count        out  5   occupancy, 0..DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x {ins,pc} array, head/tail pointers (ADDR_W, wrap mod DEPTH), count.
//  - Reset (rstn_in==0 at posedge): head=0, tail=0, count=0 -> full=0, almost_full=0,
//    decode_flag=0, count=0. Array contents not reset; ins/ins_pc don't-care while empty.
//  - Outputs combinational from state: decode_flag = rdy_in && (count!=0);
//    ins/ins_pc = mem[head] (show-ahead, zero-latency head view).
//  - push = rdy_in && !flush_in && push_valid && !full: mem[tail]<={push_ins,push_pc},
//    tail<=tail+1. Push while full is dropped silently (fetch must honour full/almost_full).
//  - pop = rdy_in && !flush_in && decode_flag && decode_ok: head<=head+1.
//    decode_ok while decode_flag==0 is ignored.
//  - count <= count + push - pop. Push and pop same cycle: count unchanged, both pointers advance.
//  - full decided on current count only: when full, a same-cycle pop does not enable a push.
//  - Entry pushed into an empty queue appears on decode_flag the following cycle (no bypass).
//  - flush_in (with rdy_in=1): head=tail=0, count=0 next cycle; overrides push and pop in
//    the same cycle (neither takes effect). decode_flag=0 the cycle after flush.
//  - rdy_in==0: no state changes, decode_flag=0, flush/push/decode_ok ignored.
//  - Reset has priority over rdy_in and flush_in; reset mid-operation discards all entries.
//  - Pointer wrap: tail DEPTH-1 -> 0 and head DEPTH-1 -> 0 with no loss; FIFO order preserved.
// TESTING
//  1. Reset then push 3 instrs (pc 0x0,0x4,0x8), decode_ok=0 -> count=3, decode_flag=1,
//     ins_pc=0x0; then decode_ok=1 three cycles -> ins_pc 0x0,0x4,0x8 popped in order, count=0.
//  2. Push 16 with no pop -> full=1 at count=16, almost_full=1 from count=14; 17th push
//     (pc 0x40) dropped; popping all yields pcs 0x0..0x3C, never 0x40.
//  3. Steady state push+pop each cycle for 40 cycles at count=5 -> count stays 5,
//     pointers wrap past 15, output pcs strictly sequential.
//  4. count=6, flush_in=1 with push_valid=1 and decode_ok=1 same cycle -> next cycle count=0,
//     decode_flag=0, pushed entry absent; next push shows up at head as only entry.
//  5. count=4, rdy_in=0 for 3 cycles with push_valid=1, decode_ok=1 -> count stays 4,
//     decode_flag=0; rdy_in=1 resumes with same head pc.
//  6. count=9, rstn_in=0 one cycle with push_valid=1 -> count=0, full=0, decode_flag=0;
//     with full queue, push+pop same cycle -> count 16->15, push dropped.

Source files
------------

// File: rtl/ins_queue.sv
// Circular instruction queue between fetch and decode: show-ahead head view,
// pop on decode_ok, whole-queue flush on mispredict, freeze while rdy_in is low.
module ins_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int AF_GAP = 2
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              push_valid,
    input  logic [31:0]       push_ins,
    input  logic [31:0]       push_pc,
    output logic              full,
    output logic              almost_full,
    output logic              decode_flag,
    output logic [31:0]       ins,
    output logic [31:0]       ins_pc,
    input  logic              decode_ok,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(DEPTH - AF_GAP);

    logic [63:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push, pop;

    assign full        = (count_q == FULL_CNT);
    assign almost_full = (count_q >= AF_CNT);
    assign decode_flag = rdy_in && (count_q != '0);
    assign count       = count_q;
    assign ins         = mem_q[head_q][63:32];
    assign ins_pc      = mem_q[head_q][31:0];

    // full is judged on the current count, so a same-cycle pop never frees a slot for push
    assign push = rdy_in && !flush_in && push_valid && !full;
    assign pop  = rdy_in && !flush_in && decode_flag && decode_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) tail_d = tail_q + 1'b1;
                if (pop)  head_d = head_q + 1'b1;
                if (push && !pop)      count_d = count_q + 1'b1;
                else if (pop && !push) count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; contents are only observed through a valid head.
    always_ff @(posedge clk_in) begin
        if (rstn_in && push) mem_q[tail_q] <= {push_ins, push_pc};
    end

endmodule

// File: tb/tb_ins_queue.sv
// Scoreboard bench for ins_queue: stimulus pushes expected {ins,pc} into a queue,
// a negedge monitor pops and compares whenever decode takes the head.
module tb_ins_queue;

    logic        clk_in = 1'b0;
    logic        rstn_in, rdy_in, flush_in, push_valid, decode_ok;
    logic [31:0] push_ins, push_pc;
    logic        full, almost_full, decode_flag;
    logic [31:0] ins, ins_pc;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    logic [63:0] exp_q [$];

    ins_queue dut (
        .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .push_valid(push_valid), .push_ins(push_ins), .push_pc(push_pc),
        .full(full), .almost_full(almost_full), .decode_flag(decode_flag),
        .ins(ins), .ins_pc(ins_pc), .decode_ok(decode_ok), .count(count)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    // Monitor: an entry leaves the queue when decode takes a valid head.
    always @(negedge clk_in) begin
        if (rstn_in === 1'b1 && rdy_in && !flush_in && decode_flag && decode_ok) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("pop_pc", ins_pc, e[31:0]);
                chk("pop_ins", ins, e[63:32]);
            end
        end
    end

    // One clock: drive inputs, check flags against the model at negedge, then advance model.
    task automatic step(input bit rst, input bit rdy, input bit flush, input bit pv,
                        input logic [31:0] pc, input bit dok);
        bit pu, po;
        rstn_in    = !rst;
        rdy_in     = rdy;
        flush_in   = flush;
        push_valid = pv;
        push_pc    = pc;
        push_ins   = ins_of(pc);
        decode_ok  = dok;
        @(negedge clk_in);
        #1;
        chk("count", 32'(count), 32'(m_cnt));
        chk("full", 32'(full), 32'(m_cnt == 16));
        chk("almost_full", 32'(almost_full), 32'(m_cnt >= 14));
        chk("decode_flag", 32'(decode_flag), 32'(rdy && m_cnt != 0));
        if (rst || (rdy && flush)) begin
            m_cnt = 0;
            exp_q.delete();
        end else if (rdy) begin
            pu = pv && (m_cnt != 16);
            po = dok && (m_cnt != 0);
            if (pu) exp_q.push_back({ins_of(pc), pc});
            m_cnt = m_cnt + int'(pu) - int'(po);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) step(0, 1, 0, 1, base + 32'(4 * i), 0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 32'h0, 1);
    endtask

    initial begin
        rstn_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; push_valid = 1'b0;
        push_ins = '0; push_pc = '0; decode_ok = 1'b0;
        @(posedge clk_in);
        #1;
        step(1, 1, 0, 0, 32'h0, 0);

        // 1: three pushes, hold, then pop in order
        push_n(3, 32'h0);
        chk("t1_count3", 32'(count), 32'd3);
        chk("t1_head_pc", ins_pc, 32'h0);
        step(0, 1, 0, 0, 32'h0, 0);
        pop_n(3);
        step(0, 1, 0, 0, 32'h0, 0);
        chk("t1_empty", 32'(count), 32'd0);

        // 2: fill to 16, drop 17th, drain
        push_n(16, 32'h0);
        chk("t2_full", 32'(full), 32'd1);
        step(0, 1, 0, 1, 32'h40, 0);
        chk("t2_drop_count", 32'(count), 32'd16);
        pop_n(16);
        chk("t2_drained", 32'(count), 32'd0);

        // 3: steady push+pop at count 5 across pointer wrap
        push_n(5, 32'h100);
        for (int i = 5; i < 45; i++) step(0, 1, 0, 1, 32'h100 + 32'(4 * i), 1);
        chk("t3_count5", 32'(count), 32'd5);
        chk("t3_head_pc", ins_pc, 32'h100 + 32'(4 * 40));
        pop_n(5);

        // 4: flush overrides push and pop
        push_n(6, 32'h200);
        step(0, 1, 1, 1, 32'h300, 1);
        chk("t4_flushed", 32'(count), 32'd0);
        step(0, 1, 0, 1, 32'h500, 0);
        chk("t4_head_pc", ins_pc, 32'h500);
        pop_n(1);

        // 5: rdy_in low freezes everything
        push_n(4, 32'h600);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h700, 1);
        chk("t5_frozen", 32'(count), 32'd4);
        chk("t5_head_pc", ins_pc, 32'h600);
        pop_n(4);

        // 6: reset mid-operation, then push+pop while full
        push_n(9, 32'h800);
        step(1, 1, 0, 1, 32'h900, 0);
        chk("t6_reset", 32'(count), 32'd0);
        push_n(16, 32'hA00);
        step(0, 1, 0, 1, 32'hB00, 1);
        chk("t6_count15", 32'(count), 32'd15);
        pop_n(15);
        step(0, 1, 0, 0, 32'h0, 0);
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
